// File: rtl/stream_pwd_ctrl_if.sv
// stream_pwd_ctrl_if: symbol stream handshake and attempt status between a
// symbol source (master) and the password controller (slave).
//   in_valid / in_sym / in_abort : source -> controller
//   in_ready                     : controller -> source, symbol accepted this cycle
//   grant / deny                 : one-cycle attempt result pulses
//   locked / fail_cnt            : lockout level and consecutive failure count
interface stream_pwd_ctrl_if;
    logic       in_valid;
    logic [5:0] in_sym;
    logic       in_abort;
    logic       in_ready;
    logic       grant;
    logic       deny;
    logic       locked;
    logic [3:0] fail_cnt;

    modport master (
        output in_valid, in_sym, in_abort,
        input  in_ready, grant, deny, locked, fail_cnt
    );

    modport slave (
        input  in_valid, in_sym, in_abort,
        output in_ready, grant, deny, locked, fail_cnt
    );
endinterface

// File: rtl/stream_pwd_ctrl.sv
// stream_pwd_ctrl: collects PW_LEN 6-bit symbols from a valid/ready stream,
// compares them against a stored password, pulses grant or deny, and locks
// out further attempts for LOCK_CYCLES cycles after MAX_FAIL consecutive
// failures.
// Ports:
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   bus (slave modport)  : in_valid/in_sym/in_abort in, in_ready/grant/deny/
//                          locked/fail_cnt out
//   prog_we/prog_addr/prog_sym : runtime password slot write, present only
//                          when PWD_PROG_EN is defined
// Optional feature macro: PWD_PROG_EN (password programmable in IDLE).
module stream_pwd_ctrl #(
    parameter int PW_LEN      = 4,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 1000,
    // The first streamed symbol (slot 0) sits in the LSBs, so this default
    // reads 01,02,03,04 in stream order.
    parameter logic [6*PW_LEN-1:0] PASSWORD = {6'h04, 6'h03, 6'h02, 6'h01}
) (
    input logic              clk,
    input logic              reset,
`ifdef PWD_PROG_EN
    input logic              prog_we,
    input logic [3:0]        prog_addr,
    input logic [5:0]        prog_sym,
`endif
    stream_pwd_ctrl_if.slave bus
);
    localparam int IW = (PW_LEN > 1) ? $clog2(PW_LEN) : 1;
    localparam int LW = $clog2(LOCK_CYCLES);

    typedef enum logic [2:0] {IDLE, COLLECT, COMPARE, GRANT, DENY, LOCKED} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [6*PW_LEN-1:0]   cap_q, cap_d;
    logic [3:0]            fail_q, fail_d;
    logic [LW-1:0]         lock_q, lock_d;
    logic [6*PW_LEN-1:0]   pwd;
    logic                  accept;

`ifdef PWD_PROG_EN
    logic [6*PW_LEN-1:0]   pwd_q, pwd_d;

    always_comb begin
        pwd_d = pwd_q;
        if (prog_we && state_q == IDLE && {1'b0, prog_addr} < 5'(PW_LEN))
            pwd_d[int'(prog_addr)*6 +: 6] = prog_sym;
    end

    always_ff @(posedge clk)
        pwd_q <= reset ? PASSWORD : pwd_d;

    assign pwd = pwd_q;
`else
    assign pwd = PASSWORD;
`endif

    // Abort wins over a symbol presented in the same cycle.
    assign accept = bus.in_valid && bus.in_ready && !bus.in_abort;

    always_ff @(posedge clk)
        state_q <= reset ? IDLE : state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q  <= '0;
            cap_q  <= '0;
            fail_q <= '0;
            lock_q <= '0;
        end else begin
            idx_q  <= idx_d;
            cap_q  <= cap_d;
            fail_q <= fail_d;
            lock_q <= lock_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cap_d   = cap_q;
        fail_d  = fail_q;
        lock_d  = lock_q;
        case (state_q)
            IDLE, COLLECT: begin
                if (bus.in_abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (accept) begin
                    cap_d[int'(idx_q)*6 +: 6] = bus.in_sym;
                    if (idx_q == IW'(PW_LEN - 1)) begin
                        state_d = COMPARE;
                        idx_d   = '0;
                    end else begin
                        state_d = COLLECT;
                        idx_d   = idx_q + IW'(1);
                    end
                end
            end
            COMPARE: begin
                if (cap_q == pwd) begin
                    state_d = GRANT;
                    fail_d  = '0;
                end else begin
                    state_d = DENY;
                    fail_d  = (fail_q == 4'(MAX_FAIL)) ? fail_q : fail_q + 4'd1;
                end
            end
            GRANT: state_d = IDLE;
            // fail_q already holds the incremented count here.
            DENY: begin
                state_d = (fail_q == 4'(MAX_FAIL)) ? LOCKED : IDLE;
                lock_d  = '0;
            end
            LOCKED: begin
                if (lock_q == LW'(LOCK_CYCLES - 1)) begin
                    state_d = IDLE;
                    fail_d  = '0;
                    lock_d  = '0;
                end else begin
                    lock_d  = lock_q + LW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = (state_q == IDLE) || (state_q == COLLECT);
        bus.grant    = (state_q == GRANT);
        bus.deny     = (state_q == DENY);
        bus.locked   = (state_q == LOCKED);
        bus.fail_cnt = fail_q;
    end
endmodule
